interval_timer_ctrl: RTL and testbench
======================================

// Module: interval_timer_ctrl
// PURPOSE
//  Sequencing controller for the 4-bit loadable binary counter (load/count/din/dout/cout).
//  Turns it into a programmable interval timer: one-shot or periodic, with a clock prescaler.
//  Raises a sticky interrupt, cleared by ack, on every expiry.
//  Sits between the CPU-side control regs and one counter instance; it drives the counter's
//  load/count/din and observes its dout/cout.
// PARAMETERS
//  WIDTH       4  counter width; must match the attached counter
//  PRESCALE_W  8  prescaler width; tick every (prescale+1) clk cycles
// PORTS
//  clk        in   1           system clock, rising edge
//  reset      in   1           asynchronous, active-low reset
//  start      in   1           start request, sampled in IDLE only
//  stop       in   1           abort; returns to IDLE, no expiry
//  mode       in   1           0 = one-shot, 1 = periodic
//  period     in   WIDTH       interval in ticks, minus 1
//  prescale   in   PRESCALE_W  tick divider, minus 1
//  irq_ack    in   1           clears irq/overrun
//  busy       out  1           1 in LOAD/RUN
//  irq        out  1           sticky expiry flag
//  overrun    out  1           expiry occurred while irq already set
//  remaining  out  WIDTH       {WIDTH{1}} - ctr_dout while busy, else 0
//  ctr_load   out  1           to counter load
//  ctr_count  out  1           to counter count
//  ctr_din    out  WIDTH       to counter din
//  ctr_dout   in   WIDTH       from counter dout
//  ctr_cout   in   1           from counter cout (dout all-ones)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; irq, overrun, busy, ctr_load, ctr_count = 0; ctr_din, remaining = 0.
//  On start, latch shadow regs L = {WIDTH{1}} - period, mode_q, prescale_q.
//  Input changes after start are ignored until the next start.
//  FSM:
//   IDLE: outputs idle. start=1 & stop=0 -> LOAD (latch shadows). stop wins over start.
//   LOAD: one cycle. ctr_load=1, ctr_din=L; prescaler cleared to 0 -> RUN.
//   RUN: prescaler increments each cycle; tick when presc==prescale_q, then presc wraps to 0.
//    tick & ctr_cout=0 -> ctr_count=1 for that cycle only.
//    tick & ctr_cout=1 -> expiry:
//     periodic: ctr_load=1, ctr_din=L that cycle; stay in RUN; prescaler keeps running.
//     one-shot: -> IDLE.
//   stop=1 in LOAD/RUN -> IDLE next edge; ctr_load/ctr_count forced 0 that cycle; no expiry, even if a tick coincides.
//  ctr_load and ctr_count are never both 1. Both are combinational from state/tick; the counter samples them on the same edge.
//  Expiry sets irq on the next edge.
//   If irq was already 1, overrun is set as well.
//   irq_ack clears irq and overrun.
//   Expiry and irq_ack in the same cycle: irq stays 1; overrun is cleared (the ack consumed the previous expiry).
//  Timing with prescale=0: first irq rises period+3 cycles after the start sampling edge.
//   Periodic expiries then repeat every period+1 cycles.
//   General interval: (period+1)*(prescale+1) cycles.
//  period=0: expires every tick. period = all-ones: L=0, full-range count.
//  Counter is never wrapped by a count; it reloads or stops at all-ones.
// TESTING
//  Bench pairs DUT with a behavioural loadable counter (sync load/count, registered dout).
//  1. prescale=0, period=3, mode=0, start@c0
//     -> ctr_load@c1 with din=12; count pulses c2..c4; irq=1@c6; busy=0@c6.
//  2. mode=1, period=3, prescale=0
//     -> expiries every 4 cycles; no ack -> overrun=1 at the 2nd expiry; irq_ack -> both 0 next cycle.
//  3. prescale=2, period=1, mode=1
//     -> ctr_count/ctr_load pulses exactly every 3 cycles; expiry interval 6 cycles.
//  4. stop asserted on the expiry tick cycle
//     -> IDLE next cycle, irq stays 0, no ctr_load; start+stop together in IDLE -> stays IDLE.
//  5. reset pulled low mid-RUN (async, between edges)
//     -> busy, irq, ctr_* drop to 0 immediately; restart works.
//  6. period=0 one-shot -> irq 3 cycles after start; period=15 -> ctr_din=0, irq after 18 cycles.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : interval_timer_ctrl
//  Purpose  : Sequencing controller that turns a loadable binary counter into
//             a programmable one-shot / periodic interval timer with a clock
//             prescaler and a sticky, acknowledgeable expiry interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module interval_timer_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,      // asynchronous, active low
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,       // 0 = one-shot, 1 = periodic
  input  logic [WIDTH-1:0]      period,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  irq_ack,
  output logic                  busy,
  output logic                  irq,
  output logic                  overrun,
  output logic [WIDTH-1:0]      remaining,
  output logic                  ctr_load,
  output logic                  ctr_count,
  output logic [WIDTH-1:0]      ctr_din,
  input  logic [WIDTH-1:0]      ctr_dout,
  input  logic                  ctr_cout
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_LOAD = 2'd1;
  localparam logic [1:0] C_RUN  = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [WIDTH-1:0]      r_load_val;   // value loaded so that expiry lands at all-ones
  logic                  r_mode;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_presc;
  logic                  w_start_ok;
  logic                  w_tick;
  logic                  w_expiry;

  // stop has priority over start; a coinciding stop also suppresses expiry
  assign w_start_ok = (r_state == C_IDLE) && start && !stop;
  assign w_tick     = (r_state == C_RUN) && (r_presc == r_prescale);
  assign w_expiry   = w_tick && ctr_cout && !stop;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= C_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE: if (w_start_ok) w_next_state = C_LOAD;
      C_LOAD: w_next_state = stop ? C_IDLE : C_RUN;
      C_RUN: begin
        if (stop)                     w_next_state = C_IDLE;
        else if (w_expiry && !r_mode) w_next_state = C_IDLE;
      end
      default: w_next_state = C_IDLE;
    endcase
  end

  // Output decode; counter controls are combinational so the counter acts on the same edge
  always_comb begin
    busy      = 1'b0;
    ctr_load  = 1'b0;
    ctr_count = 1'b0;
    ctr_din   = '0;
    remaining = '0;
    case (r_state)
      C_LOAD: begin
        busy      = 1'b1;
        ctr_din   = r_load_val;
        ctr_load  = !stop;
        remaining = {WIDTH{1'b1}} - ctr_dout;
      end
      C_RUN: begin
        busy      = 1'b1;
        ctr_din   = r_load_val;
        remaining = {WIDTH{1'b1}} - ctr_dout;
        if (w_tick && !stop) begin
          if (!ctr_cout)   ctr_count = 1'b1;
          else if (r_mode) ctr_load  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shadow registers: configuration is frozen at the accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load_val <= '0;
      r_mode     <= 1'b0;
      r_prescale <= '0;
    end else if (w_start_ok) begin
      r_load_val <= {WIDTH{1'b1}} - period;
      r_mode     <= mode;
      r_prescale <= prescale;
    end
  end

  // Prescaler: cleared while loading, wraps to 0 on every tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (r_state == C_LOAD) begin
      r_presc <= '0;
    end else if (r_state == C_RUN) begin
      if (w_tick) r_presc <= '0;
      else        r_presc <= r_presc + PRESCALE_W'(1);
    end
  end

  // Sticky interrupt; an ack in the expiry cycle consumes the earlier event only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq     <= 1'b0;
      overrun <= 1'b0;
    end else if (w_expiry) begin
      irq     <= 1'b1;
      overrun <= irq_ack ? 1'b0 : (overrun | irq);
    end else if (irq_ack) begin
      irq     <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interval_timer_ctrl
//  Purpose  : Directed self-checking bench for interval_timer_ctrl paired with
//             a behavioural 4-bit loadable counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] period = '0;
  logic [7:0] prescale = '0;
  logic       irq_ack = 1'b0;
  logic       busy, irq, overrun, ctr_load, ctr_count, ctr_cout;
  logic [3:0] remaining, ctr_din;
  logic [3:0] ctr_dout = '0;

  int total = 0;
  int bad   = 0;

  interval_timer_ctrl #(.WIDTH(4), .PRESCALE_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .period(period), .prescale(prescale), .irq_ack(irq_ack),
    .busy(busy), .irq(irq), .overrun(overrun), .remaining(remaining),
    .ctr_load(ctr_load), .ctr_count(ctr_count), .ctr_din(ctr_din),
    .ctr_dout(ctr_dout), .ctr_cout(ctr_cout)
  );

  always #5 clk = ~clk;

  // Behavioural loadable counter: synchronous load/count, registered dout
  always @(posedge clk) begin
    if (ctr_load)       ctr_dout <= ctr_din;
    else if (ctr_count) ctr_dout <= ctr_dout + 4'd1;
  end
  assign ctr_cout = (ctr_dout == 4'hF);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({busy, irq, overrun, ctr_load, ctr_count} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000", {busy, irq, overrun, ctr_load, ctr_count});
    end
    total++;
    if ({ctr_din, remaining} !== 8'h00) begin
      bad++;
      $display("FAIL reset_buses got=%h want=00", {ctr_din, remaining});
    end
    @(posedge clk);
    #1 reset = 1'b1;
    step;
  endtask

  // period=3 one-shot; inputs altered after start must be ignored
  task automatic test_oneshot;
    period = 4'd3; prescale = 8'd0; mode = 1'b0; start = 1'b1;
    step;  // c1
    start = 1'b0; period = 4'd9; prescale = 8'd5; mode = 1'b1;
    total++;
    if ({ctr_load, busy, ctr_din} !== {2'b11, 4'd12}) begin
      bad++;
      $display("FAIL oneshot_load got=%b/%b/%0d want=1/1/12", ctr_load, busy, ctr_din);
    end
    for (int c = 2; c <= 6; c++) begin
      step;
      total++;
      if ({ctr_count, ctr_load, irq, busy} !== {(c >= 2 && c <= 4), 1'b0, (c == 6), (c <= 5)}) begin
        bad++;
        $display("FAIL oneshot_c%0d cnt/ld/irq/busy got=%b want=%b", c,
                 {ctr_count, ctr_load, irq, busy}, {(c >= 2 && c <= 4), 1'b0, (c == 6), (c <= 5)});
      end
      if (c == 2) begin
        total++;
        if (remaining !== 4'd3) begin
          bad++;
          $display("FAIL oneshot_remaining got=%0d want=3", remaining);
        end
      end
    end
    irq_ack = 1'b1;
    step;
    irq_ack = 1'b0;
    total++;
    if ({irq, overrun} !== 2'b00) begin
      bad++;
      $display("FAIL oneshot_ack got=%b want=00", {irq, overrun});
    end
  endtask

  // period=3 periodic; overrun on 2nd expiry, ack coinciding with expiry
  task automatic test_periodic;
    logic ld_e, cnt_e, irq_e, ovr_e;
    period = 4'd3; prescale = 8'd0; mode = 1'b1; start = 1'b1;
    step;  // c1
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      ld_e  = (c % 4 == 1);
      cnt_e = (c >= 2) && !ld_e;
      irq_e = (c >= 6) && (c <= 14);
      ovr_e = (c >= 10) && (c <= 13);
      total++;
      if ({ctr_load, ctr_count, irq, overrun} !== {ld_e, cnt_e, irq_e, ovr_e}) begin
        bad++;
        $display("FAIL periodic_c%0d ld/cnt/irq/ovr got=%b want=%b", c,
                 {ctr_load, ctr_count, irq, overrun}, {ld_e, cnt_e, irq_e, ovr_e});
      end
      irq_ack = (c == 13) || (c == 14);
      step;
    end
    irq_ack = 1'b0;
    stop = 1'b1;
    step;
    stop = 1'b0;
    total++;
    if ({busy, irq} !== 2'b00) begin
      bad++;
      $display("FAIL periodic_stop busy/irq got=%b want=00", {busy, irq});
    end
  endtask

  // prescale=2, period=1 periodic: pulses every 3 cycles, expiry every 6
  task automatic test_prescale;
    period = 4'd1; prescale = 8'd2; mode = 1'b1; start = 1'b1;
    step;  // c1
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      total++;
      if ({ctr_load, ctr_count, irq} !== {(c % 6 == 1), (c % 6 == 4), (c >= 8)}) begin
        bad++;
        $display("FAIL prescale_c%0d ld/cnt/irq got=%b want=%b", c,
                 {ctr_load, ctr_count, irq}, {(c % 6 == 1), (c % 6 == 4), (c >= 8)});
      end
      if (c != 14) step;
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL prescale_overrun got=%b want=1", overrun);
    end
    stop = 1'b1; irq_ack = 1'b1;
    step;
    stop = 1'b0; irq_ack = 1'b0;
    total++;
    if ({busy, irq, overrun} !== 3'b000) begin
      bad++;
      $display("FAIL prescale_stop got=%b want=000", {busy, irq, overrun});
    end
  endtask

  // stop on the expiry tick, then start+stop together in IDLE
  task automatic test_stop;
    period = 4'd0; prescale = 8'd0; mode = 1'b1; start = 1'b1;
    step;  // c1
    start = 1'b0;
    step;  // c2: expiry tick, would reload
    total++;
    if (ctr_load !== 1'b1) begin
      bad++;
      $display("FAIL stop_pre_reload got=%b want=1", ctr_load);
    end
    stop = 1'b1;
    #1;
    total++;
    if ({ctr_load, ctr_count} !== 2'b00) begin
      bad++;
      $display("FAIL stop_forced got=%b want=00", {ctr_load, ctr_count});
    end
    step;
    stop = 1'b0;
    total++;
    if ({busy, irq, ctr_load} !== 3'b000) begin
      bad++;
      $display("FAIL stop_idle got=%b want=000", {busy, irq, ctr_load});
    end
    start = 1'b1; stop = 1'b1;
    step;
    total++;
    if ({busy, ctr_load} !== 2'b00) begin
      bad++;
      $display("FAIL start_stop_idle got=%b want=00", {busy, ctr_load});
    end
    start = 1'b0; stop = 1'b0;
    step;
  endtask

  // async reset between edges mid-RUN, then one-shot period=0 restart
  task automatic test_async_reset;
    period = 4'd3; prescale = 8'd0; mode = 1'b1; start = 1'b1;
    step;  // c1
    start = 1'b0;
    repeat (6) step;  // c7
    total++;
    if ({busy, irq, ctr_count} !== 3'b111) begin
      bad++;
      $display("FAIL areset_pre got=%b want=111", {busy, irq, ctr_count});
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy, irq, overrun, ctr_load, ctr_count, ctr_din, remaining} !== 13'b0) begin
      bad++;
      $display("FAIL areset_drop got=%b want=0", {busy, irq, overrun, ctr_load, ctr_count, ctr_din, remaining});
    end
    @(negedge clk);
    reset = 1'b1;
    step;
    period = 4'd0; mode = 1'b0; start = 1'b1;
    step;  // c1
    start = 1'b0;
    total++;
    if ({ctr_load, ctr_din} !== {1'b1, 4'd15}) begin
      bad++;
      $display("FAIL restart_load got=%b/%0d want=1/15", ctr_load, ctr_din);
    end
    step;  // c2
    step;  // c3
    total++;
    if ({irq, busy} !== 2'b10) begin
      bad++;
      $display("FAIL restart_p0_irq irq/busy got=%b want=10", {irq, busy});
    end
    irq_ack = 1'b1;
    step;
    irq_ack = 1'b0;
  endtask

  // period=15: L=0, full-range count, irq at c18
  task automatic test_full_range;
    period = 4'd15; prescale = 8'd0; mode = 1'b0; start = 1'b1;
    step;  // c1
    start = 1'b0;
    total++;
    if ({ctr_load, ctr_din} !== {1'b1, 4'd0}) begin
      bad++;
      $display("FAIL full_load got=%b/%0d want=1/0", ctr_load, ctr_din);
    end
    for (int c = 2; c <= 18; c++) begin
      step;
      total++;
      if ({irq, busy} !== {(c == 18), (c <= 17)}) begin
        bad++;
        $display("FAIL full_c%0d irq/busy got=%b want=%b", c, {irq, busy}, {(c == 18), (c <= 17)});
      end
    end
    irq_ack = 1'b1;
    step;
    irq_ack = 1'b0;
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_periodic;
    test_prescale;
    test_stop;
    test_async_reset;
    test_full_range;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
